// File: rtl/nock_increment.sv
`default_nettype none
// ============================================================================
//  Module      : nock_increment
//  Description : Execute-stage operator for Nock opcode 4 (increment).
//                Receives an opcode-4 stack cell from the traversal FSM,
//                computes operand+1 and patches the resulting atom into the
//                parent cell's pointer slot, or overwrites the cell in place
//                when it is the root. It then returns a sys_func/state pair
//                to the traverser.
//
//  Ports
//    clk, rst                  clock; asynchronous active-low reset
//    start                     high while the traversal mux selects this unit
//    in_addr, in_data          opcode-4 stack cell address and word
//    parent_addr               parent of in_addr (all-ones = NIL = root)
//    mem_ready, read_data1     memory completion strobe and read data
//    mem_execute, address1,
//    mem_func, write_data      single-cycle memory request
//    module_address            address the traverser resumes from
//    module_finished           operation complete (held until start drops)
//    error                     error code, 0 = none
//    execute_return_sys_func,
//    execute_return_state      hand-back pair for the traverser
//
//  Word layout : {tag[TAG_W-1:0], hed[NOUN_W-1:0], tel[NOUN_W-1:0]}
//                tag[1] = hed is pointer, tag[0] = tel is pointer
//
//  Revision    : 1.0  initial release
// ============================================================================
module nock_increment #(
    parameter int          ADDR_W    = 11,
    parameter int          NOUN_W    = 28,
    parameter int          TAG_W     = 8,
    parameter int          DATA_W    = TAG_W + 2 * NOUN_W,
    parameter logic [1:0]  FUNC_GET  = 2'd1,
    parameter logic [1:0]  FUNC_SET  = 2'd2,
    parameter logic [3:0]  RET_FUNC  = 4'h0,
    parameter logic [3:0]  RET_STATE = 4'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [ADDR_W-1:0]   parent_addr,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   read_data1,
    output logic                mem_execute,
    output logic [ADDR_W-1:0]   address1,
    output logic [1:0]          mem_func,
    output logic [DATA_W-1:0]   write_data,
    output logic [ADDR_W-1:0]   module_address,
    output logic                module_finished,
    output logic [7:0]          error,
    output logic [3:0]          execute_return_sys_func,
    output logic [3:0]          execute_return_state
);

    localparam logic [ADDR_W-1:0] c_NIL       = {ADDR_W{1'b1}};
    localparam logic [NOUN_W-1:0] c_NOUN_ONES = {NOUN_W{1'b1}};
    localparam logic [NOUN_W-1:0] c_NOUN_ONE  = {{(NOUN_W-1){1'b0}}, 1'b1};
    localparam int                c_TEL_LSB   = 0;
    localparam int                c_HED_LSB   = NOUN_W;
    localparam int                c_TAG_LSB   = 2 * NOUN_W;
    localparam int                c_ADDR_PAD  = NOUN_W - ADDR_W;

    localparam logic [7:0] c_ERR_CELL     = 8'h04;
    localparam logic [7:0] c_ERR_OVERFLOW = 8'h05;
    localparam logic [7:0] c_ERR_ORPHAN   = 8'h06;
    localparam logic [3:0] c_ERR_FUNC     = 4'h3;
    localparam logic [3:0] c_ERR_STATE    = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CHECK   = 4'd1,
        S_RD_PAR  = 4'd2,
        S_RD_WAIT = 4'd3,
        S_PATCH   = 4'd4,
        S_WR      = 4'd5,
        S_WR_ROOT = 4'd6,
        S_WR_WAIT = 4'd7,
        S_DONE    = 4'd8,
        S_ERROR   = 4'd9
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Latched operation context
    logic [ADDR_W-1:0]   r_in_addr;
    logic [ADDR_W-1:0]   r_parent;
    logic [NOUN_W-1:0]   r_tel;
    logic                r_tel_is_ptr;
    logic [NOUN_W-1:0]   r_res;
    logic [DATA_W-1:0]   r_word;      // parent word, later the patched word
    logic [7:0]          r_error;

    // Patch datapath
    logic [TAG_W-1:0]    w_ptag;
    logic [NOUN_W-1:0]   w_phed;
    logic [NOUN_W-1:0]   w_ptel;
    logic [NOUN_W-1:0]   w_self_ref;
    logic                w_hit_hed;
    logic                w_hit_tel;
    logic [DATA_W-1:0]   w_patched;
    logic                w_is_root;

    // Only the operand tel and its pointer flag matter from the stack cell.
    logic                w_unused;
    assign w_unused = ^{in_data[DATA_W-1:c_TAG_LSB+1], in_data[c_TAG_LSB-1:c_HED_LSB]};

    assign w_is_root  = (r_parent == c_NIL);
    assign w_ptag     = r_word[c_TAG_LSB +: TAG_W];
    assign w_phed     = r_word[c_HED_LSB +: NOUN_W];
    assign w_ptel     = r_word[c_TEL_LSB +: NOUN_W];
    assign w_self_ref = {{c_ADDR_PAD{1'b0}}, r_in_addr};

    // The hed slot wins if both slots happen to point at this cell.
    assign w_hit_hed = w_ptag[1] && (w_phed == w_self_ref);
    assign w_hit_tel = w_ptag[0] && (w_ptel == w_self_ref);

    always_comb begin
        w_patched = r_word;
        if (w_hit_hed) begin
            w_patched[c_HED_LSB +: NOUN_W] = r_res;
            w_patched[c_TAG_LSB + 1]       = 1'b0;
        end else if (w_hit_tel) begin
            w_patched[c_TEL_LSB +: NOUN_W] = r_res;
            w_patched[c_TAG_LSB]           = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Dropping start anywhere before DONE/ERROR aborts.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!start) begin
                    w_next_state = S_IDLE;
                end else if (r_tel_is_ptr || (r_tel == c_NOUN_ONES)) begin
                    w_next_state = S_ERROR;
                end else if (w_is_root) begin
                    w_next_state = S_WR_ROOT;
                end else begin
                    w_next_state = S_RD_PAR;
                end
            end
            S_RD_PAR: begin
                w_next_state = start ? S_RD_WAIT : S_IDLE;
            end
            S_RD_WAIT: begin
                if (!start) begin
                    w_next_state = S_IDLE;
                end else if (mem_ready) begin
                    w_next_state = S_PATCH;
                end
            end
            S_PATCH: begin
                if (!start) begin
                    w_next_state = S_IDLE;
                end else if (w_hit_hed || w_hit_tel) begin
                    w_next_state = S_WR;
                end else begin
                    w_next_state = S_ERROR;
                end
            end
            S_WR, S_WR_ROOT: begin
                w_next_state = start ? S_WR_WAIT : S_IDLE;
            end
            S_WR_WAIT: begin
                if (!start) begin
                    w_next_state = S_IDLE;
                end else if (mem_ready) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE, S_ERROR: begin
                if (!start) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_addr    <= '0;
            r_parent     <= '0;
            r_tel        <= '0;
            r_tel_is_ptr <= 1'b0;
            r_res        <= '0;
            r_word       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in_addr    <= in_addr;
                        r_parent     <= parent_addr;
                        r_tel        <= in_data[c_TEL_LSB +: NOUN_W];
                        r_tel_is_ptr <= in_data[c_TAG_LSB];
                    end
                end
                S_CHECK: begin
                    // Overflow is trapped in CHECK, so this never wraps when used.
                    r_res <= r_tel + c_NOUN_ONE;
                end
                S_RD_WAIT: begin
                    if (mem_ready) begin
                        r_word <= read_data1;
                    end
                end
                S_PATCH: begin
                    r_word <= w_patched;
                end
                default: begin
                end
            endcase
        end
    end

    // Error code: set on entry to ERROR, cleared whenever the FSM returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_error <= 8'h00;
        end else if (w_next_state == S_IDLE) begin
            r_error <= 8'h00;
        end else if (r_state == S_CHECK && w_next_state == S_ERROR) begin
            r_error <= r_tel_is_ptr ? c_ERR_CELL : c_ERR_OVERFLOW;
        end else if (r_state == S_PATCH && w_next_state == S_ERROR) begin
            r_error <= c_ERR_ORPHAN;
        end
    end

    assign error = r_error;

    // ------------------------------------------------------------------
    // Outputs. The memory request is gated with start so that an abort
    // in an issue state never reaches the memory port.
    // ------------------------------------------------------------------
    always_comb begin
        mem_execute             = 1'b0;
        address1                = '0;
        mem_func                = 2'b00;
        write_data              = '0;
        module_address          = '0;
        module_finished         = 1'b0;
        execute_return_sys_func = 4'h0;
        execute_return_state    = 4'h0;
        case (r_state)
            S_RD_PAR: begin
                if (start) begin
                    mem_execute = 1'b1;
                    address1    = r_parent;
                    mem_func    = FUNC_GET;
                end
            end
            S_WR: begin
                if (start) begin
                    mem_execute = 1'b1;
                    address1    = r_parent;
                    mem_func    = FUNC_SET;
                    write_data  = r_word;
                end
            end
            S_WR_ROOT: begin
                if (start) begin
                    mem_execute = 1'b1;
                    address1    = r_in_addr;
                    mem_func    = FUNC_SET;
                    write_data  = {{TAG_W{1'b0}}, {NOUN_W{1'b0}}, r_res};
                end
            end
            S_DONE: begin
                module_finished         = 1'b1;
                module_address          = w_is_root ? r_in_addr : r_parent;
                execute_return_sys_func = RET_FUNC;
                execute_return_state    = RET_STATE;
            end
            S_ERROR: begin
                module_finished         = 1'b1;
                module_address          = r_in_addr;
                execute_return_sys_func = c_ERR_FUNC;
                execute_return_state    = c_ERR_STATE;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nock_increment.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nock_increment
//  Description : Self-checking bench for nock_increment with a behavioural
//                memory responder and a reference model of the increment rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nock_increment;

    localparam logic [10:0] NIL = 11'h7FF;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] in_addr;
    logic [63:0] in_data;
    logic [10:0] parent_addr;
    logic        mem_ready;
    logic [63:0] read_data1;
    logic        mem_execute;
    logic [10:0] address1;
    logic [1:0]  mem_func;
    logic [63:0] write_data;
    logic [10:0] module_address;
    logic        module_finished;
    logic [7:0]  error;
    logic [3:0]  execute_return_sys_func;
    logic [3:0]  execute_return_state;

    int n_cmp = 0;
    int n_bad = 0;

    nock_increment dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .in_addr                 (in_addr),
        .in_data                 (in_data),
        .parent_addr             (parent_addr),
        .mem_ready               (mem_ready),
        .read_data1              (read_data1),
        .mem_execute             (mem_execute),
        .address1                (address1),
        .mem_func                (mem_func),
        .write_data              (write_data),
        .module_address          (module_address),
        .module_finished         (module_finished),
        .error                   (error),
        .execute_return_sys_func (execute_return_sys_func),
        .execute_return_state    (execute_return_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Memory responder: logs every request, answers after 'delay'
    // extra cycles, and flags malformed request pulses.
    // ---------------------------------------------------------------
    logic [63:0] mem [0:2047];
    logic [1:0]  log_f [$];
    logic [10:0] log_a [$];
    logic [63:0] log_d [$];
    int          delay = 0;
    int          exec_viol = 0;
    int          cnt = 0;
    logic        busy = 1'b0;
    logic        prev_exec = 1'b0;
    logic [63:0] pend = '0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (!rst) begin
            busy      = 1'b0;
            prev_exec = 1'b0;
        end else begin
            if (prev_exec && mem_execute) exec_viol++;
            if (prev_exec && !mem_execute && (mem_func != 2'd0 || write_data != 64'd0)) exec_viol++;
            prev_exec = mem_execute;
            if (busy) begin
                if (cnt == 0) begin
                    mem_ready  = 1'b1;
                    read_data1 = pend;
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mem_execute) begin
                log_f.push_back(mem_func);
                log_a.push_back(address1);
                log_d.push_back(write_data);
                if (mem_func == 2'd2) mem[address1] = write_data;
                pend = mem[address1];
                busy = 1'b1;
                cnt  = delay;
            end
        end
    end

    // ---------------------------------------------------------------
    // Reference model: what the operator must do for one stack cell.
    // ---------------------------------------------------------------
    function automatic void ref_model(
        input  logic [10:0] a, input logic [63:0] d, input logic [10:0] p, input logic [63:0] pw,
        output int n_ops, output logic do_get, output logic [10:0] set_addr, output logic [63:0] set_data,
        output logic [7:0] err, output logic [10:0] maddr, output logic [3:0] rf, output logic [3:0] rs);
        logic [27:0] res;
        logic [63:0] w;
        n_ops = 0; do_get = 1'b0; set_addr = '0; set_data = '0; err = 8'h00;
        if (d[56]) begin
            err = 8'h04;
        end else if (d[27:0] == 28'hFFFFFFF) begin
            err = 8'h05;
        end else begin
            res = d[27:0] + 28'd1;
            if (p == NIL) begin
                n_ops = 1; set_addr = a; set_data = {36'd0, res};
            end else begin
                do_get = 1'b1; n_ops = 1; w = pw; set_addr = p;
                if (pw[57] && pw[55:28] == {17'd0, a}) begin
                    w[55:28] = res; w[57] = 1'b0; n_ops = 2;
                end else if (pw[56] && pw[27:0] == {17'd0, a}) begin
                    w[27:0] = res; w[56] = 1'b0; n_ops = 2;
                end else begin
                    err = 8'h06;
                end
                set_data = w;
            end
        end
        maddr = (err != 8'h00 || p == NIL) ? a : p;
        rf    = (err != 8'h00) ? 4'h3 : 4'h0;
        rs    = (err != 8'h00) ? 4'hF : 4'h0;
    endfunction

    // Run one operation to completion and score it against the model.
    task automatic exec_op(input logic [10:0] a, input logic [63:0] d, input logic [10:0] p,
                           input int dly, input string nm);
        int n_ops, cyc, viol0, idx;
        logic do_get;
        logic [10:0] s_a, m_a;
        logic [63:0] s_d, pw;
        logic [7:0] e;
        logic [3:0] rf, rs;
        pw = (p == NIL) ? 64'd0 : mem[p];
        ref_model(a, d, p, pw, n_ops, do_get, s_a, s_d, e, m_a, rf, rs);
        log_f.delete(); log_a.delete(); log_d.delete();
        delay = dly;
        viol0 = exec_viol;
        in_addr = a; in_data = d; parent_addr = p; start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!module_finished && cyc < 200);
        n_cmp++;
        if (module_finished !== 1'b1) begin n_bad++; $display("FAIL %s timeout: finished=%b want 1", nm, module_finished); end
        n_cmp++;
        if (error !== e) begin n_bad++; $display("FAIL %s error: got %h want %h", nm, error, e); end
        n_cmp++;
        if (module_address !== m_a) begin n_bad++; $display("FAIL %s module_address: got %0d want %0d", nm, module_address, m_a); end
        n_cmp++;
        if ({execute_return_sys_func, execute_return_state} !== {rf, rs})
            begin n_bad++; $display("FAIL %s return: got %h/%h want %h/%h", nm, execute_return_sys_func, execute_return_state, rf, rs); end
        // Hold start high: must not re-trigger and must keep results.
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (module_finished !== 1'b1 || error !== e)
            begin n_bad++; $display("FAIL %s hold: finished=%b error=%h want 1/%h", nm, module_finished, error, e); end
        n_cmp++;
        if (log_f.size() != n_ops) begin n_bad++; $display("FAIL %s op count: got %0d want %0d", nm, log_f.size(), n_ops); end
        idx = 0;
        if (do_get && log_f.size() > 0) begin
            n_cmp++;
            if (log_f[0] !== 2'd1 || log_a[0] !== p)
                begin n_bad++; $display("FAIL %s get: got f%0d @%0d want f1 @%0d", nm, log_f[0], log_a[0], p); end
            idx = 1;
        end
        if (e == 8'h00 && log_f.size() > idx) begin
            n_cmp++;
            if (log_f[idx] !== 2'd2 || log_a[idx] !== s_a || log_d[idx] !== s_d)
                begin n_bad++; $display("FAIL %s set: got f%0d @%0d %h want f2 @%0d %h", nm, log_f[idx], log_a[idx], log_d[idx], s_a, s_d); end
        end
        n_cmp++;
        if (exec_viol !== viol0) begin n_bad++; $display("FAIL %s pulse shape: got %0d bad pulses want 0", nm, exec_viol - viol0); end
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (module_finished !== 1'b0 || error !== 8'h00)
            begin n_bad++; $display("FAIL %s release: finished=%b error=%h want 0/00", nm, module_finished, error); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        n_cmp++;
        if ({mem_execute, address1, mem_func, write_data, module_address, module_finished, error,
             execute_return_sys_func, execute_return_state} !== '0)
            begin n_bad++; $display("FAIL %s outputs: exec=%b a=%0d f=%0d wd=%h ma=%0d fin=%b err=%h rf=%h rs=%h want all 0",
                nm, mem_execute, address1, mem_func, write_data, module_address, module_finished, error,
                execute_return_sys_func, execute_return_state); end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; in_addr = '0; in_data = '0; parent_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_directed();
        exec_op(11'd5, {8'hC0, 28'd4, 28'd41}, NIL, 0, "root");
        mem[9] = {8'h03, 28'd5, 28'd7};
        exec_op(11'd5, {8'hC0, 28'd4, 28'd0}, 11'd9, 1, "parent_patch");
        exec_op(11'd5, {8'hC1, 28'd4, 28'd3}, 11'd9, 0, "operand_cell");
        exec_op(11'd5, {8'hC0, 28'd4, 28'hFFFFFFF}, 11'd9, 0, "overflow");
        mem[9] = {8'h03, 28'd6, 28'd7};
        exec_op(11'd5, {8'hC0, 28'd4, 28'd1}, 11'd9, 2, "orphan");
        mem[12] = {8'h01, 28'd3, 28'd5};
        exec_op(11'd5, {8'hC0, 28'd0, 28'd9}, 11'd12, 0, "tel_patch");
        exec_op(11'd8, {8'hC0, 28'd0, 28'hFFFFFFE}, NIL, 0, "max_no_wrap");
    endtask

    task automatic test_random();
        logic [10:0] a, p;
        logic [63:0] d, pw;
        for (int i = 0; i < 40; i++) begin
            a = 11'($urandom_range(0, 2046));
            if ($urandom_range(0, 3) == 0) p = NIL;
            else begin
                do p = 11'($urandom_range(0, 2046)); while (p == a);
            end
            pw = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0: begin pw[55:28] = {17'd0, a}; pw[57] = 1'b1; end
                1: begin pw[27:0] = {17'd0, a}; pw[56] = 1'b1; end
                2: begin pw[55:28] = {17'd0, a}; pw[27:0] = {17'd0, a}; pw[57:56] = 2'b11; end
                3: begin pw[55:28] = {17'd0, a}; pw[57] = 1'b0; pw[27:0] = {17'd0, a}; end
                default: begin end
            endcase
            if (p != NIL) mem[p] = pw;
            d = {$urandom(), $urandom()};
            d[56] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) d[27:0] = 28'hFFFFFFF;
            exec_op(a, d, p, int'($urandom_range(0, 4)), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_handshake_stress();
        mem[20] = {8'hC2, 28'd30, 28'd99};
        exec_op(11'd30, {8'hC0, 28'd1, 28'd500}, 11'd20, 7, "slow_mem");
    endtask

    task automatic test_back_to_back();
        mem[40] = {8'h03, 28'd44, 28'd45};
        exec_op(11'd44, {8'hC0, 28'd0, 28'd10}, 11'd40, 0, "b2b_first");
        exec_op(11'd45, {8'hC0, 28'd0, 28'd20}, 11'd40, 0, "b2b_second");
    endtask

    task automatic test_abort_rd_wait();
        int cyc;
        mem[9] = {8'h03, 28'd5, 28'd7};
        log_f.delete(); log_a.delete(); log_d.delete();
        delay = 10;
        in_addr = 11'd5; in_data = {8'hC0, 28'd0, 28'd3}; parent_addr = 11'd9; start = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (log_f.size() == 0 && cyc < 50);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        n_cmp++;
        if (log_f.size() != 1) begin n_bad++; $display("FAIL abort op count: got %0d want 1", log_f.size()); end
        check_all_zero("abort_idle");
        exec_op(11'd5, {8'hC0, 28'd0, 28'd3}, 11'd9, 0, "after_abort");
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        mem[9] = {8'h03, 28'd5, 28'd7};
        log_f.delete(); log_a.delete(); log_d.delete();
        delay = 10;
        in_addr = 11'd5; in_data = {8'hC0, 28'd0, 28'd3}; parent_addr = 11'd9; start = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (log_f.size() < 2 && cyc < 80);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst = 1'b1;
        @(posedge clk); #1;
        mem[9] = {8'h03, 28'd5, 28'd7};
        exec_op(11'd5, {8'hC0, 28'd0, 28'd3}, 11'd9, 1, "after_reset");
    endtask

    initial begin
        mem_ready  = 1'b0;
        read_data1 = '0;
        test_reset();
        test_directed();
        test_random();
        test_handshake_stress();
        test_back_to_back();
        test_abort_rd_wait();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
